// File: rtl/cv32e40x_xif_result_fifo_pkg.sv
// Shared types and defaults for the eXtension-interface result FIFO.
// The struct here uses the default widths; the FIFO rebuilds the same
// layout locally from its own parameters.
package cv32e40x_xif_result_fifo_pkg;

    localparam int X_ID_WIDTH_DEFAULT  = 4;
    localparam int X_RFW_WIDTH_DEFAULT = 32;
    localparam int RD_WIDTH            = 5;

    // Result entry as carried from the coprocessor to write-back
    typedef struct packed {
        logic [X_ID_WIDTH_DEFAULT-1:0]  id;
        logic [X_RFW_WIDTH_DEFAULT-1:0] data;
        logic [RD_WIDTH-1:0]            rd;
        logic                           we;
        logic                           exc;
    } xif_result_t;

    localparam int XIF_RESULT_WIDTH = $bits(xif_result_t);

    // Packed width of one entry for arbitrary id/data widths
    function automatic int result_entry_width(input int id_w, input int rfw_w);
        return id_w + rfw_w + RD_WIDTH + 2;
    endfunction

endpackage

// File: rtl/cv32e40x_xif_result_fifo.sv
// In-order result FIFO between the coprocessor result channel and WB.
// Results are accepted whenever space exists and presented to WB from a
// registered head entry; there is no empty-bypass, so a push becomes
// visible one cycle later. A flush discards everything.
module cv32e40x_xif_result_fifo
    import cv32e40x_xif_result_fifo_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int X_ID_WIDTH  = X_ID_WIDTH_DEFAULT,
    parameter int X_RFW_WIDTH = X_RFW_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     xif_result_valid_i,
    output logic                     xif_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]    xif_result_id_i,
    input  logic [X_RFW_WIDTH-1:0]   xif_result_data_i,
    input  logic [RD_WIDTH-1:0]      xif_result_rd_i,
    input  logic                     xif_result_we_i,
    input  logic                     xif_result_exc_i,
    output logic                     wb_result_valid_o,
    input  logic                     wb_result_ready_i,
    output logic [X_ID_WIDTH-1:0]    wb_result_id_o,
    output logic [X_RFW_WIDTH-1:0]   wb_result_data_o,
    output logic [RD_WIDTH-1:0]      wb_result_rd_o,
    output logic                     wb_result_we_o,
    output logic                     wb_result_exc_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = result_entry_width(X_ID_WIDTH, X_RFW_WIDTH);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [RD_WIDTH-1:0]    rd;
        logic                   we;
        logic                   exc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               push;
    logic               pop;

    // Handshake decode; ready depends only on the registered count
    always_comb begin
        xif_result_ready_o = (count_q < CNT_W'(DEPTH));
        wb_result_valid_o  = (count_q != '0);
        push               = xif_result_valid_i && xif_result_ready_o && !flush_i;
        pop                = wb_result_valid_o && wb_result_ready_i && !flush_i;
        wr_entry           = '{id:   xif_result_id_i,
                               data: xif_result_data_i,
                               rd:   xif_result_rd_i,
                               we:   xif_result_we_i,
                               exc:  xif_result_exc_i};
        head               = mem_q[rptr_q];
    end

    // Entry storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    // Pointers and occupancy counter; flush overrides any handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Sticky debug flag: coprocessor offered a result while we were full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (xif_result_valid_i && !xif_result_ready_o) begin
            overflow_q <= 1'b1;
        end
    end

    assign count_o          = count_q;
    assign overflow_o       = overflow_q;
    assign wb_result_id_o   = head.id;
    assign wb_result_data_o = head.data;
    assign wb_result_rd_o   = head.rd;
    assign wb_result_we_o   = head.we;
    assign wb_result_exc_o  = head.exc;

`ifndef SYNTHESIS
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop |-> (count_q != '0));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q < CNT_W'(DEPTH)));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_result_valid_o && !wb_result_ready_i && !flush_i) |=>
        ($stable(head) && wb_result_valid_o));
`endif

endmodule

// File: tb/tb_cv32e40x_xif_result_fifo.sv
// Directed, table-driven bench for the XIF result FIFO (DEPTH = 2).
module tb_cv32e40x_xif_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        xif_result_valid_i;
    logic        xif_result_ready_o;
    logic [3:0]  xif_result_id_i;
    logic [31:0] xif_result_data_i;
    logic [4:0]  xif_result_rd_i;
    logic        xif_result_we_i;
    logic        xif_result_exc_i;
    logic        wb_result_valid_o;
    logic        wb_result_ready_i;
    logic [3:0]  wb_result_id_o;
    logic [31:0] wb_result_data_o;
    logic [4:0]  wb_result_rd_o;
    logic        wb_result_we_o;
    logic        wb_result_exc_o;
    logic        flush_i;
    logic [1:0]  count_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic        wb_ready;
        logic        flush;
        logic [1:0]  exp_count;
        logic        exp_valid;
        logic [3:0]  exp_id;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_we;
        logic        exp_exc;
        logic        exp_ready;
        logic        exp_ovf;
    } vec_t;

    localparam int NUM_VECS = 13;
    vec_t vecs [NUM_VECS];

    cv32e40x_xif_result_fifo #(
        .DEPTH(2),
        .X_ID_WIDTH(4),
        .X_RFW_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xif_result_valid_i(xif_result_valid_i),
        .xif_result_ready_o(xif_result_ready_o),
        .xif_result_id_i(xif_result_id_i),
        .xif_result_data_i(xif_result_data_i),
        .xif_result_rd_i(xif_result_rd_i),
        .xif_result_we_i(xif_result_we_i),
        .xif_result_exc_i(xif_result_exc_i),
        .wb_result_valid_o(wb_result_valid_o),
        .wb_result_ready_i(wb_result_ready_i),
        .wb_result_id_o(wb_result_id_o),
        .wb_result_data_o(wb_result_data_o),
        .wb_result_rd_o(wb_result_rd_o),
        .wb_result_we_o(wb_result_we_o),
        .wb_result_exc_o(wb_result_exc_o),
        .flush_i(flush_i),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic v, input logic [3:0] id, input logic [31:0] data,
        input logic [4:0] rd, input logic we, input logic exc,
        input logic wbr, input logic fl,
        input logic [1:0] cnt, input logic val, input logic [3:0] hid,
        input logic [31:0] hdata, input logic [4:0] hrd, input logic hwe,
        input logic hexc, input logic rdy, input logic ovf);
        vec_t t;
        t.valid = v;       t.id = id;         t.data = data;
        t.rd = rd;         t.we = we;         t.exc = exc;
        t.wb_ready = wbr;  t.flush = fl;
        t.exp_count = cnt; t.exp_valid = val; t.exp_id = hid;
        t.exp_data = hdata; t.exp_rd = hrd;   t.exp_we = hwe;
        t.exp_exc = hexc;  t.exp_ready = rdy; t.exp_ovf = ovf;
        return t;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        xif_result_valid_i = v.valid;
        xif_result_id_i    = v.id;
        xif_result_data_i  = v.data;
        xif_result_rd_i    = v.rd;
        xif_result_we_i    = v.we;
        xif_result_exc_i   = v.exc;
        wb_result_ready_i  = v.wb_ready;
        flush_i            = v.flush;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkValue({tag, " count"},    32'(count_o),            32'(v.exp_count));
        checkValue({tag, " wb_valid"}, 32'(wb_result_valid_o),  32'(v.exp_valid));
        checkValue({tag, " x_ready"},  32'(xif_result_ready_o), 32'(v.exp_ready));
        checkValue({tag, " overflow"}, 32'(overflow_o),         32'(v.exp_ovf));
        if (v.exp_valid) begin
            checkValue({tag, " id"},   32'(wb_result_id_o),   32'(v.exp_id));
            checkValue({tag, " data"}, wb_result_data_o,      v.exp_data);
            checkValue({tag, " rd"},   32'(wb_result_rd_o),   32'(v.exp_rd));
            checkValue({tag, " we"},   32'(wb_result_we_o),   32'(v.exp_we));
            checkValue({tag, " exc"},  32'(wb_result_exc_o),  32'(v.exp_exc));
        end
    endtask

    // Apply one vector for a cycle and check the state just after the edge
    task automatic stepAndCheck(input string tag, input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag, v);
    endtask

    initial begin
        vec_t idle;
        vec_t v;

        //            v  id  data          rd we ex wbr fl | cnt val hid hdata        hrd we ex rdy ovf
        vecs[0]  = mk(1, 3, 32'hDEAD_BEEF, 5, 1, 0, 0, 0,   1, 1, 3, 32'hDEAD_BEEF, 5, 1, 0, 1, 0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 0, 0, 1, 0,   0, 0, 0, 32'h0,         0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 1, 32'h1111_1111, 1, 1, 0, 0, 0,   1, 1, 1, 32'h1111_1111, 1, 1, 0, 1, 0);
        vecs[3]  = mk(1, 2, 32'h2222_2222, 2, 0, 1, 0, 0,   2, 1, 1, 32'h1111_1111, 1, 1, 0, 0, 0);
        vecs[4]  = mk(1, 9, 32'h9999_9999, 9, 1, 1, 0, 0,   2, 1, 1, 32'h1111_1111, 1, 1, 0, 0, 1);
        vecs[5]  = mk(1, 9, 32'h9999_9999, 9, 1, 1, 1, 0,   1, 1, 2, 32'h2222_2222, 2, 0, 1, 1, 1);
        vecs[6]  = mk(0, 0, 32'h0,         0, 0, 0, 1, 0,   0, 0, 0, 32'h0,         0, 0, 0, 1, 1);
        vecs[7]  = mk(1, 7, 32'h7777_7777, 7, 1, 0, 0, 0,   1, 1, 7, 32'h7777_7777, 7, 1, 0, 1, 1);
        vecs[8]  = mk(1, 4, 32'h4444_4444, 4, 1, 0, 1, 0,   1, 1, 4, 32'h4444_4444, 4, 1, 0, 1, 1);
        vecs[9]  = mk(1, 5, 32'h5555_5555, 5, 0, 0, 0, 0,   2, 1, 4, 32'h4444_4444, 4, 1, 0, 0, 1);
        vecs[10] = mk(1, 6, 32'h6666_6666, 6, 1, 0, 0, 1,   0, 0, 0, 32'h0,         0, 0, 0, 1, 1);
        vecs[11] = mk(1, 8, 32'h8888_8888, 8, 1, 0, 1, 1,   0, 0, 0, 32'h0,         0, 0, 0, 1, 1);
        vecs[12] = mk(0, 0, 32'h0,         0, 0, 0, 0, 0,   0, 0, 0, 32'h0,         0, 0, 0, 1, 1);

        idle = mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0);

        // Reset and check reset values
        applyStimulus(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", idle);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: latency, fill/overflow/ordering, push+pop, flush
        for (int i = 0; i < NUM_VECS; i++) begin
            stepAndCheck($sformatf("vec%0d", i), vecs[i]);
        end

        // Ten alternating push/pop rounds across pointer wraps
        for (int k = 1; k <= 10; k++) begin
            v = mk(1, 4'(k), 32'h1000_0000 + 32'(k), 5'(k), k[0], k[1], 0, 0,
                   1, 1, 4'(k), 32'h1000_0000 + 32'(k), 5'(k), k[0], k[1], 1, 1);
            stepAndCheck($sformatf("alt_push%0d", k), v);
            v = mk(0, 0, 32'h0, 0, 0, 0, 1, 0,
                   0, 0, 0, 32'h0, 0, 0, 0, 1, 1);
            stepAndCheck($sformatf("alt_pop%0d", k), v);
        end

        // Fill to two, then reset asynchronously mid-cycle
        v = mk(1, 10, 32'hA0A0_A0A0, 10, 1, 0, 0, 0,
               1, 1, 10, 32'hA0A0_A0A0, 10, 1, 0, 1, 1);
        stepAndCheck("mid_fill1", v);
        v = mk(1, 11, 32'hB0B0_B0B0, 11, 0, 0, 0, 0,
               2, 1, 10, 32'hA0A0_A0A0, 10, 1, 0, 0, 1);
        stepAndCheck("mid_fill2", v);
        applyStimulus(idle);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset", idle);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = mk(1, 12, 32'hC0DE_C0DE, 12, 1, 1, 0, 0,
               1, 1, 12, 32'hC0DE_C0DE, 12, 1, 1, 1, 0);
        stepAndCheck("post_reset_push", v);
        v = mk(0, 0, 32'h0, 0, 0, 0, 1, 0,
               0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
        stepAndCheck("post_reset_pop", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
